// File: rtl/regfile_write_arbiter.sv
// Four-source arbiter (ALU, MEM, LINK, SP) for the single register-file write port.
// Define WRARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority LINK > MEM > SP > ALU.
module regfile_write_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6,
    parameter int STALL_CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     hold,
    input  logic [3:0]               req_valid,
    output logic [3:0]               req_ready,
    input  logic [4*ADDR_W-1:0]      req_addr,
    input  logic [4*DATA_W-1:0]      req_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [(1<<ADDR_W)-1:0]   pending_mask,
    output logic                     stall,
    output logic [STALL_CNT_W-1:0]   stall_cycles
);

    localparam int NUM_REQ = 4;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] SP_ADDR   = ADDR_W'(2);

    logic [ADDR_W-1:0] eff_addr [NUM_REQ];
    logic [DATA_W-1:0] req_word [NUM_REQ];
    logic [1:0]        grant_idx;
    logic              grant_found;
    logic              any_grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // LINK and SP have architecturally fixed destinations; their address slices are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[4*ADDR_W-1:2*ADDR_W];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
            if (gi == 2) begin : g_link
                assign eff_addr[gi] = LINK_ADDR;
            end else if (gi == 3) begin : g_sp
                assign eff_addr[gi] = SP_ADDR;
            end else begin : g_slice
                assign eff_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            end
        end
    endgenerate

`ifdef WRARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr;
    logic [1:0] scan_idx;

    // Search upward from rr_ptr, wrapping mod 4; first valid requester wins.
    always_comb begin
        grant_idx   = 2'd0;
        grant_found = 1'b0;
        scan_idx    = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = rr_ptr + 2'(k);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= 2'd0;
        end else if (any_grant) begin
            rr_ptr <= grant_idx + 2'd1;
        end
    end
`else
    always_comb begin
        grant_idx   = 2'd0;
        grant_found = 1'b1;
        if (req_valid[2]) begin
            grant_idx = 2'd2;
        end else if (req_valid[1]) begin
            grant_idx = 2'd1;
        end else if (req_valid[3]) begin
            grant_idx = 2'd3;
        end else if (req_valid[0]) begin
            grant_idx = 2'd0;
        end else begin
            grant_found = 1'b0;
        end
    end
`endif

    always_comb begin
        req_ready = 4'b0000;
        if (!hold && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign any_grant = |req_ready;
    assign stall     = |(req_valid & ~req_ready);
    assign sel_addr  = eff_addr[grant_idx];
    assign sel_data  = req_word[grant_idx];

    // Writes to register 0 are accepted but never reach the bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (any_grant) begin
            wr_en   <= (sel_addr != '0);
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                pending_mask[eff_addr[i]] = 1'b1;
            end
        end
        if (wr_en) begin
            pending_mask[wr_addr] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a queue-free behavioural model.
// Follows WRARB_ROUND_ROBIN_EN like the design; stall counter narrowed so saturation is reachable.
module tb_regfile_write_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 6;
    localparam int SCW = 4;
    localparam int NR  = 1 << AW;

    logic            clock = 1'b0;
    logic            reset;
    logic            hold;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [4*AW-1:0] req_addr;
    logic [4*DW-1:0] req_data;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [NR-1:0]   pending_mask;
    logic            stall;
    logic [SCW-1:0]  stall_cycles;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STALL_CNT_W(SCW)) dut (
        .clock(clock), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pending_mask(pending_mask), .stall(stall), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Requester state and model of the architectural outputs
    bit            r_valid [4];
    logic [AW-1:0] r_addr  [4];
    logic [DW-1:0] r_data  [4];
    bit            r_hold;
    int            m_ptr;
    bit            m_wr_en;
    int            m_wr_addr;
    logic [DW-1:0] m_wr_data;
    int            m_stalls;

    function automatic int eff_addr(int i);
        if (i == 2) return 1;
        if (i == 3) return 2;
        return int'(r_addr[i]);
    endfunction

    function automatic int pick();
`ifdef WRARB_ROUND_ROBIN_EN
        if (r_hold) return -1;
        for (int k = 0; k < 4; k++) begin
            if (r_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
`else
        int order [4];
        order = '{2, 1, 3, 0};
        if (r_hold) return -1;
        for (int k = 0; k < 4; k++) begin
            if (r_valid[order[k]]) return order[k];
        end
        return -1;
`endif
    endfunction

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]          = r_valid[i];
            req_addr[i*AW +: AW]  = r_addr[i];
            req_data[i*DW +: DW]  = r_data[i];
        end
        hold = r_hold;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < 4; i++) begin
            r_valid[i] = 0;
            r_addr[i]  = '0;
            r_data[i]  = '0;
        end
        r_hold = 0;
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_wr_en   = 0;
        m_wr_addr = 0;
        m_wr_data = '0;
        m_stalls  = 0;
    endtask

    // One cycle: drive at negedge, check just after, advance model at posedge.
    task automatic step(output int g, output logic [3:0] rdy);
        logic [NR-1:0] exp_mask;
        logic [3:0]    exp_ready;
        bit            exp_stall;
        int            e;
        apply();
        #1;
        g = pick();
        exp_ready = 4'b0000;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_mask  = '0;
        exp_stall = 0;
        for (int i = 0; i < 4; i++) begin
            if (r_valid[i]) begin
                exp_mask[eff_addr(i)] = 1'b1;
                if (i != g) exp_stall = 1;
            end
        end
        if (m_wr_en) exp_mask[m_wr_addr] = 1'b1;
        exp_mask[0] = 1'b0;
        rdy = req_ready;
        check("req_ready", req_ready, exp_ready);
        check("stall", stall, exp_stall);
        check("pending_mask", pending_mask, exp_mask);
        check("wr_en", wr_en, m_wr_en);
        check("wr_addr", wr_addr, m_wr_addr);
        check("wr_data", wr_data, m_wr_data);
        check("stall_cycles", stall_cycles, m_stalls);
        @(posedge clock);
        if (exp_stall && m_stalls < (1 << SCW) - 1) m_stalls++;
        if (g >= 0) begin
            e = eff_addr(g);
            m_wr_en   = (e != 0);
            m_wr_addr = e;
            m_wr_data = r_data[g];
            m_ptr     = (g + 1) % 4;
            $display("xfer src=%0d addr=%0d data=%h", g, e, r_data[g]);
        end else begin
            m_wr_en = 0;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        apply();
        @(negedge clock);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_stall_cycles", stall_cycles, 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    int         g;
    logic [3:0] rdy;
    int         exp_seq [5];

    initial begin
        reset = 1'b1;
        clear_reqs();
        apply();
        do_reset();

        // ALU write to r5
        r_valid[0] = 1; r_addr[0] = 6'd5; r_data[0] = 32'hDEADBEEF;
        step(g, rdy);
        r_valid[0] = 0;
        check("t1_ready", rdy, 4'b0001);
        check("t1_wr_en", wr_en, 1);
        check("t1_wr_addr", wr_addr, 5);
        check("t1_wr_data", wr_data, 32'hDEADBEEF);
        check("t1_pend5", pending_mask[5], 1);
        step(g, rdy);

        // LINK forced to r1, SP forced to r2
        r_valid[2] = 1; r_addr[2] = 6'd9; r_data[2] = 32'h00400010;
        step(g, rdy);
        r_valid[2] = 0;
        check("t2_link_addr", wr_addr, 1);
        r_valid[3] = 1; r_data[3] = 32'h7FFFFFFC;
        step(g, rdy);
        r_valid[3] = 0;
        check("t2_sp_addr", wr_addr, 2);
        check("t2_sp_data", wr_data, 32'h7FFFFFFC);

        // Write to r0 is accepted and discarded
        r_valid[0] = 1; r_addr[0] = 6'd0; r_data[0] = 32'h1234;
        step(g, rdy);
        r_valid[0] = 0;
        check("t3_ready", rdy, 4'b0001);
        check("t3_wr_en", wr_en, 0);
        check("t3_pend0", pending_mask[0], 0);
        step(g, rdy);

        // All four valid from reset
        do_reset();
`ifdef WRARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{2, 2, 2, 2, 2};
`endif
        for (int i = 0; i < 4; i++) begin
            r_valid[i] = 1; r_addr[i] = AW'(10 + i); r_data[i] = DW'(32'hA000 + i);
        end
        for (int k = 0; k < 5; k++) begin
            step(g, rdy);
            check("t4_order", rdy, 4'b0001 << exp_seq[k]);
        end
        check("t4_stalls", stall_cycles, 5);

        // Hold for three cycles with MEM valid
        do_reset();
        r_valid[1] = 1; r_addr[1] = 6'd17; r_data[1] = 32'hCAFE0001;
        r_hold = 1;
        for (int k = 0; k < 3; k++) step(g, rdy);
        check("t5_stalls", stall_cycles, 3);
        r_hold = 0;
        step(g, rdy);
        r_valid[1] = 0;
        check("t5_release", rdy, 4'b0010);
        check("t5_wr_addr", wr_addr, 17);

        // Asynchronous reset directly after a transfer
        r_valid[1] = 1; r_addr[1] = 6'd7; r_data[1] = 32'h0BADF00D;
        step(g, rdy);
        r_valid[1] = 0;
        check("t6_pre_wr_en", wr_en, 1);
        reset = 1'b1;
        #1;
        check("t6_async_wr_en", wr_en, 0);
        check("t6_async_stalls", stall_cycles, 0);
        clear_reqs();
        apply();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            r_valid[i] = 1; r_addr[i] = AW'(20 + i); r_data[i] = DW'(i);
        end
        step(g, rdy);
`ifdef WRARB_ROUND_ROBIN_EN
        check("t6_ptr0", rdy, 4'b0001);
`else
        check("t6_ptr0", rdy, 4'b0100);
`endif

        // Stall counter saturation
        for (int k = 0; k < 20; k++) step(g, rdy);
        check("t7_saturate", stall_cycles, (1 << SCW) - 1);

        // Random traffic obeying the handshake
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!r_valid[i] && ($urandom % 2 == 0)) begin
                    r_valid[i] = 1;
                    r_addr[i]  = ($urandom % 6 == 0) ? '0 : AW'($urandom);
                    r_data[i]  = DW'($urandom);
                end
            end
            r_hold = ($urandom % 6 == 0);
            step(g, rdy);
            if (g >= 0) r_valid[g] = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
